divider14: RTL
==============

DIVIDER14 -- requirements
Module: divider14

Interface
REQ-001 SHALL have parameter DW, default 14, dividend/quotient width (matches the 7x7 multiplier product width).
REQ-002 SHALL have parameter VW, default 7, divisor/remainder width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  request; sampled only while not busy.
REQ-006 SHALL have port dividend  input  DW  unsigned numerator; captured on accepted start.
REQ-007 SHALL have port divisor  input  VW  unsigned denominator; captured on accepted start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when results become valid.
REQ-010 SHALL have port quotient  output  DW  result; held until next done.
REQ-011 SHALL have port remainder  output  VW  result; held until next done.
REQ-012 SHALL have port dbz  output  1  divide-by-zero flag; valid with done, held until next done.

Function
REQ-013 SHALL implement FSM states IDLE and CALC; busy = (state==CALC).
REQ-014 SHALL accept start at an edge where state==IDLE and start==1; that edge is cycle k.
REQ-015 SHALL, at accept with divisor!=0, latch operands, clear partial remainder (VW+1 bits), load iteration counter = DW-1, enter CALC.
REQ-016 SHALL perform restoring division, MSB first, one quotient bit per edge: shift {rem, next dividend bit}; if shifted >= divisor, subtract and set bit to 1, else keep and set bit to 0.
REQ-017 SHALL complete the DW-th iteration at edge k+DW (k+14 at default), loading quotient/remainder, pulsing done, and returning to IDLE at that edge.
REQ-018 SHALL, at accept with divisor==0, skip CALC: at edge k+1 assert done, dbz=1, quotient=all ones (14'h3FFF), remainder=0.
REQ-019 SHALL clear dbz on any normal completion.
REQ-020 SHALL ignore start while busy; latched operands unaffected by input changes during CALC.
REQ-021 SHALL accept a new start in the cycle done is high (state already IDLE); back-to-back throughput one result per DW+1 cycles.
REQ-022 SHALL keep done low except for the single completion cycle.
REQ-023 SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor for all divisor!=0.

Reset
REQ-024 SHALL, when rst_n==0 at a clock edge, force state=IDLE, busy=0, done=0, dbz=0, quotient=0, remainder=0, counter=0.
REQ-025 SHALL abort an in-progress operation on reset with no done pulse and no partial result visible.
REQ-026 SHALL give reset priority over start at the same edge.

Structure
REQ-027 SHALL place DW, VW, derived counter width $clog2(DW), and the FSM state enumeration in a shared calculator package.
REQ-028 SHALL use one sub-module div_step: combinational compare/subtract for one restoring iteration (inputs partial remainder, divisor; outputs next remainder, quotient bit).
REQ-029 SHALL not use any built-in / or % operator.

Verification
REQ-030 SHALL verify: dividend=100, divisor=7, start at k -> busy k+1..k+14, done at k+14, quotient=14, remainder=2, dbz=0.
REQ-031 SHALL verify: dividend=16383, divisor=127 -> quotient=129, remainder=0; dividend=132, divisor=11 -> quotient=12, remainder=0 (inverse of multiplier 12*11).
REQ-032 SHALL verify: dividend=5, divisor=0 -> done at k+1, dbz=1, quotient=14'h3FFF, remainder=0; following 9/4 -> quotient=2, remainder=1, dbz=0.
REQ-033 SHALL verify: start=1 with new operands (50/5) at k+5 during busy -> ignored; first result unchanged, no extra done.
REQ-034 SHALL verify: rst_n=0 at k+7 mid-operation -> next cycle busy=0, done=0, quotient=0, remainder=0; no done pulse afterwards without new start.
REQ-035 SHALL verify: start held high across done -> second operation accepted in done cycle; random 1000-operand sweep checks REQ-023.

Source files
------------

// File: rtl/divider14_pkg.sv
// Shared widths, counter sizing and FSM encoding for the divider14 restoring divider.
package divider14_pkg;

  localparam int DIV_DW = 14;
  localparam int DIV_VW = 7;

  function automatic int cnt_width(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

  localparam int DIV_CW = cnt_width(DIV_DW);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

endpackage

// File: rtl/divider14_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none; evaluated every cycle, consumed only while the top is calculating.
module div_step
  import divider14_pkg::*;
#(
  parameter int VW = DIV_VW
) (
  input  logic [VW:0]   prem,
  input  logic          din,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   nrem,
  output logic          qbit
);

  // The full {prem, din} is compared so the partial remainder's top bit takes part,
  // even though a correctly running divider always keeps it at zero.
  assign qbit = ({prem, din} >= {2'b00, divisor});
  assign nrem = qbit ? ({prem[VW-1:0], din} - {1'b0, divisor})
                     : {prem[VW-1:0], din};

endmodule

// File: rtl/divider14.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
// Latency: done DW edges after an accepted start, or 1 edge for a zero divisor.
// Backpressure: start is ignored while busy; a start held across done is taken in the done cycle.
module divider14
  import divider14_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dbz
);

  localparam int CW = cnt_width(DW);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] work;
  logic [VW-1:0] dvs;
  logic [VW:0]   prem;
  logic          dbz_pend;
  logic [VW:0]   nrem;
  logic          qbit;

  // work shifts dividend bits out of its MSB while quotient bits fill in at its LSB.
  div_step #(.VW(VW)) u_step (
    .prem    (prem),
    .din     (work[DW-1]),
    .divisor (dvs),
    .nrem    (nrem),
    .qbit    (qbit)
  );

  assign busy = (state == CALC);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      dvs       <= '0;
      prem      <= '0;
      dbz_pend  <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      done     <= 1'b0;
      dbz_pend <= 1'b0;

      // A zero divisor never enters CALC; its result is published one edge after accept.
      if (dbz_pend) begin
        done      <= 1'b1;
        dbz       <= 1'b1;
        quotient  <= '1;
        remainder <= '0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              dbz_pend <= 1'b1;
            end else begin
              work  <= dividend;
              dvs   <= divisor;
              prem  <= '0;
              cnt   <= CW'(DW - 1);
              state <= CALC;
            end
          end
        end
        CALC: begin
          work <= {work[DW-2:0], qbit};
          prem <= nrem;
          if (cnt == '0) begin
            quotient  <= {work[DW-2:0], qbit};
            remainder <= nrem[VW-1:0];
            dbz       <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
